hc595_shift_ctrl: RTL and testbench
===================================

// Module: hc595_shift_ctrl
// PURPOSE
//  Downstream output stage of the key/RAM display path. Takes one parallel
//  14-bit display word ({seg[7:0], sel[5:0]}) per load handshake. Serialises it MSB-first
//  into two cascaded 74HC595s and drives ds/shcp/stcp/oe to the board
//  segment-display pins. One word per transfer; upstream waits on ready.
// PARAMETERS
//  WIDTH  14  bits per transfer (chain length of the cascaded 595s)
//  DIV    2   sys_clk cycles per shcp half-period (shcp = sys_clk/(2*DIV)); DIV>=1
// PORTS
//  sys_clk   in   1      system clock, 50 MHz, all logic on rising edge
//  sys_rst   in   1      synchronous reset, active-high
//  data_in   in   WIDTH  word to shift; data_in[WIDTH-1] shifted first
//  load      in   1      request; accepted only in the cycle where load & ready
//  ready     out  1      1 = idle, can accept a word
//  ds        out  1      595 serial data
//  shcp      out  1      595 shift clock
//  stcp      out  1      595 storage (latch) clock
//  oe        out  1      595 output enable, active-low
// BEHAVIOUR
//  Reset (sys_rst=1 sampled): state=IDLE, ds=0, shcp=0, stcp=0, oe=1, ready=1;
//   shift reg and counters cleared; load ignored while sys_rst=1.
//  FSM: IDLE -> SHIFT on load&ready; SHIFT -> LATCH after WIDTH bit slots;
//   LATCH -> IDLE after DIV cycles. All outputs registered.
//  Let T = cycle load&ready sampled. data_in captured at T. ready=0 from T+1.
//  Bit slot i (i=0..WIDTH-1) spans 2*DIV cycles starting T+1+i*2*DIV:
//   ds = data_in[WIDTH-1-i] for the whole slot; shcp=0 for the first DIV
//   cycles, 1 for the last DIV cycles (rising edge mid-slot, ds stable DIV
//   cycles either side of it).
//  Phase counter 0..2*DIV-1 wraps each slot; bit counter 0..WIDTH-1.
//  LATCH: shcp=0, stcp=1 for cycles T+1+WIDTH*2*DIV .. +DIV-1; ds holds last bit.
//  IDLE re-entered with stcp=0, ready=1 at T+1+WIDTH*2*DIV+DIV
//   (DIV=2,WIDTH=14: stcp high T+57..T+58, ready high T+59).
//  oe: 1 from reset until end of first LATCH, then 0 permanently (until reset).
//  ds=0 in IDLE.
//  load while ready=0: ignored, no queuing; data_in changes during a
//   transfer have no effect.
//  load in the same cycle ready returns to 1: accepted (back-to-back, no gap).
//  Reset mid-transfer: immediate return to reset values next cycle; no stcp
//   pulse, partially shifted word discarded; oe returns to 1.
// CONFIGURATION
//  HC595_BLANK_EN defined: extra input port blank (1 bit, after load).
//   blank=1 sampled -> oe=1 next cycle. blank=0 -> oe follows normal rule next cycle.
//   Shifting/latching unaffected by blank.
//  Not defined: no blank port; oe governed only by the rule above.
// TESTING
//  1 reset: hold sys_rst 3 cycles -> ds=0 shcp=0 stcp=0 oe=1 ready=1.
//  2 load 14'h2AAB at T (DIV=2) -> ds 1,0,1,0,...,1,1 per slot; 14 shcp rises
//    at T+3+4i; stcp=1 only at T+57,T+58; ready=1 at T+59; oe=0 from T+59.
//  3 load 14'h3FFF at T, second load 14'h0000 at T+10 -> second ignored;
//    ds=1 for all slots; exactly one stcp pulse.
//  4 back-to-back: load held high with 14'h0001 then 14'h2000 -> second
//    accepted at T+59; second stcp high at T+116..T+117.
//  5 sys_rst=1 at T+22 mid-transfer -> reset values next cycle, no stcp
//    pulse, oe=1, ready=1; new load afterwards completes normally.
//  6 HC595_BLANK_EN: after a completed transfer, blank=1 for 5 cycles ->
//    oe=1 for those 5 cycles (1-cycle delay), then oe=0; shift unaffected.

Source files
------------

// File: rtl/hc595_shift_ctrl.sv
// Serialises one WIDTH-bit display word MSB-first into cascaded 74HC595s (ds/shcp/stcp/oe).
// Optional HC595_BLANK_EN adds a blank input that forces oe high one cycle after it is sampled.
//
// state | meaning
// IDLE  | ready=1, ds=0, waiting for load
// SHIFT | WIDTH bit slots of 2*DIV cycles, shcp high in the second half
// LATCH | stcp high for DIV cycles, ds holds the last bit
module hc595_shift_ctrl #(
    parameter int WIDTH = 14,
    parameter int DIV   = 2
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load,
`ifdef HC595_BLANK_EN
    input  logic             blank,
`endif
    output logic             ready,
    output logic             ds,
    output logic             shcp,
    output logic             stcp,
    output logic             oe
);

    localparam int PW = (2 * DIV > 1) ? $clog2(2 * DIV) : 1;
    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [PW-1:0] PH_LAST    = PW'(2 * DIV - 1);
    localparam logic [PW-1:0] PH_HI      = PW'(DIV);
    localparam logic [PW-1:0] LATCH_LAST = PW'(DIV - 1);
    localparam logic [BW-1:0] BIT_LAST   = BW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LATCH = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [PW-1:0]    phase_q, phase_d;
    logic [BW-1:0]    bit_q, bit_d;
    logic             ds_q, ds_d;
    logic             shcp_q, shcp_d;
    logic             stcp_q, stcp_d;
    logic             ready_q, ready_d;
    logic             oe_q, oe_d;
    logic             done_q, done_d;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q <= IDLE;
            shift_q <= '0;
            phase_q <= '0;
            bit_q   <= '0;
            ds_q    <= 1'b0;
            shcp_q  <= 1'b0;
            stcp_q  <= 1'b0;
            ready_q <= 1'b1;
            oe_q    <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            phase_q <= phase_d;
            bit_q   <= bit_d;
            ds_q    <= ds_d;
            shcp_q  <= shcp_d;
            stcp_q  <= stcp_d;
            ready_q <= ready_d;
            oe_q    <= oe_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        phase_d = phase_q;
        bit_d   = bit_q;
        ds_d    = ds_q;
        shcp_d  = shcp_q;
        stcp_d  = stcp_q;
        ready_d = ready_q;
        done_d  = done_q;

        case (state_q)
            IDLE: begin
                ds_d    = 1'b0;
                shcp_d  = 1'b0;
                stcp_d  = 1'b0;
                ready_d = 1'b1;
                if (load && ready_q) begin
                    state_d = SHIFT;
                    shift_d = data_in;
                    ds_d    = data_in[WIDTH-1];
                    phase_d = '0;
                    bit_d   = '0;
                    ready_d = 1'b0;
                end
            end
            SHIFT: begin
                if (phase_q == PH_LAST) begin
                    phase_d = '0;
                    shcp_d  = 1'b0;
                    if (bit_q == BIT_LAST) begin
                        state_d = LATCH;
                        stcp_d  = 1'b1;
                    end else begin
                        bit_d   = bit_q + 1'b1;
                        shift_d = {shift_q[WIDTH-2:0], 1'b0};
                        ds_d    = shift_q[WIDTH-2];
                    end
                end else begin
                    phase_d = phase_q + 1'b1;
                    shcp_d  = (phase_d >= PH_HI);
                end
            end
            LATCH: begin
                if (phase_q == LATCH_LAST) begin
                    state_d = IDLE;
                    stcp_d  = 1'b0;
                    ds_d    = 1'b0;
                    ready_d = 1'b1;
                    done_d  = 1'b1;
                    phase_d = '0;
                    bit_d   = '0;
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // oe stays high until the first word has been latched into the outputs
`ifdef HC595_BLANK_EN
        oe_d = ~done_d | blank;
`else
        oe_d = ~done_d;
`endif
    end

    assign ready = ready_q;
    assign ds    = ds_q;
    assign shcp  = shcp_q;
    assign stcp  = stcp_q;
    assign oe    = oe_q;

endmodule

// File: tb/tb_hc595_shift_ctrl.sv
// Directed bench for hc595_shift_ctrl (WIDTH=14, DIV=2); inputs driven and outputs checked on negedge.
module tb_hc595_shift_ctrl;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic [13:0] data_in = '0;
    logic        load    = 1'b0;
    logic        blank   = 1'b0;
    logic        ready, ds, shcp, stcp, oe;

    int compared   = 0;
    int mismatched = 0;

    always #10 sys_clk = ~sys_clk;

    hc595_shift_ctrl #(.WIDTH(14), .DIV(2)) dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .data_in (data_in),
        .load    (load),
`ifdef HC595_BLANK_EN
        .blank   (blank),
`endif
        .ready   (ready),
        .ds      (ds),
        .shcp    (shcp),
        .stcp    (stcp),
        .oe      (oe)
    );

    task automatic test_reset();
        sys_rst = 1'b1;
        repeat (3) @(negedge sys_clk);
        compared++;
        if ({ds, shcp, stcp, oe, ready} !== 5'b00011) begin
            mismatched++;
            $display("FAIL reset_values: got ds/shcp/stcp/oe/ready=%b want 00011",
                     {ds, shcp, stcp, oe, ready});
        end
        sys_rst = 1'b0;
        @(negedge sys_clk);
        compared++;
        if ({ds, shcp, stcp, oe, ready} !== 5'b00011) begin
            mismatched++;
            $display("FAIL idle_after_reset: got %b want 00011", {ds, shcp, stcp, oe, ready});
        end
    endtask

    // Full per-cycle check of one transfer of 14'h2AAB; first transfer after reset so oe goes 1 -> 0.
    task automatic test_pattern();
        logic [13:0] w;
        int rises;
        logic prev_shcp;
        logic e_ds, e_shcp, e_stcp, e_rdy, e_oe;
        w = 14'h2AAB;
        rises = 0;
        prev_shcp = 1'b0;
        compared++;
        if (ready !== 1'b1) begin
            mismatched++;
            $display("FAIL pattern_ready_before: got %b want 1", ready);
        end
        data_in = w;
        load = 1'b1;
        for (int k = 1; k <= 59; k++) begin
            @(negedge sys_clk);
            load = 1'b0;
            data_in = 14'h0000;
            if (k <= 56) begin
                e_ds   = w[13 - (k - 1) / 4];
                e_shcp = (((k - 1) % 4) >= 2);
                e_stcp = 1'b0;
                e_rdy  = 1'b0;
            end else if (k <= 58) begin
                e_ds   = w[0];
                e_shcp = 1'b0;
                e_stcp = 1'b1;
                e_rdy  = 1'b0;
            end else begin
                e_ds   = 1'b0;
                e_shcp = 1'b0;
                e_stcp = 1'b0;
                e_rdy  = 1'b1;
            end
            e_oe = (k < 59);
            if (shcp && !prev_shcp) begin
                rises++;
                compared++;
                if (((k - 3) % 4) != 0 || k < 3) begin
                    mismatched++;
                    $display("FAIL pattern_shcp_rise: rise at T+%0d, want T+3+4i", k);
                end
            end
            prev_shcp = shcp;
            compared++;
            if ({ds, shcp, stcp, ready, oe} !== {e_ds, e_shcp, e_stcp, e_rdy, e_oe}) begin
                mismatched++;
                $display("FAIL pattern_T+%0d: got ds/shcp/stcp/ready/oe=%b want %b",
                         k, {ds, shcp, stcp, ready, oe}, {e_ds, e_shcp, e_stcp, e_rdy, e_oe});
            end
        end
        compared++;
        if (rises != 14) begin
            mismatched++;
            $display("FAIL pattern_rise_count: got %0d want 14", rises);
        end
    endtask

    // 14'h3FFF accepted; a second load of 14'h0000 at T+10 must be ignored.
    task automatic test_ignore();
        int stcp_cycles, pulses;
        logic prev_stcp;
        stcp_cycles = 0;
        pulses = 0;
        prev_stcp = 1'b0;
        data_in = 14'h3FFF;
        load = 1'b1;
        for (int k = 1; k <= 62; k++) begin
            @(negedge sys_clk);
            if (k <= 56) begin
                compared++;
                if (ds !== 1'b1) begin
                    mismatched++;
                    $display("FAIL ignore_ds_T+%0d: got %b want 1", k, ds);
                end
            end
            if (stcp) stcp_cycles++;
            if (stcp && !prev_stcp) pulses++;
            prev_stcp = stcp;
            if (k == 59 || k == 62) begin
                compared++;
                if (ready !== 1'b1 || oe !== 1'b0) begin
                    mismatched++;
                    $display("FAIL ignore_idle_T+%0d: got ready=%b oe=%b want 1 0", k, ready, oe);
                end
            end
            load = (k == 10);
            data_in = (k == 10) ? 14'h0000 : 14'h1555;
        end
        compared++;
        if (pulses != 1 || stcp_cycles != 2) begin
            mismatched++;
            $display("FAIL ignore_stcp: got pulses=%0d cycles=%0d want 1 2", pulses, stcp_cycles);
        end
    endtask

    // load held high: 14'h0001 then 14'h2000 accepted at T+59 with no gap.
    task automatic test_back_to_back();
        logic [13:0] w;
        int j;
        logic e_ds, e_shcp, e_stcp, e_rdy;
        data_in = 14'h0001;
        load = 1'b1;
        for (int k = 1; k <= 118; k++) begin
            @(negedge sys_clk);
            data_in = 14'h2000;
            if (k == 60) load = 1'b0;
            w = (k <= 59) ? 14'h0001 : 14'h2000;
            j = (k <= 59) ? k : k - 59;
            e_ds   = 1'b0;
            e_shcp = 1'b0;
            e_stcp = 1'b0;
            e_rdy  = 1'b0;
            if (j <= 56) begin
                e_ds   = w[13 - (j - 1) / 4];
                e_shcp = (((j - 1) % 4) >= 2);
            end else if (j <= 58) begin
                e_ds   = w[0];
                e_stcp = 1'b1;
            end else begin
                e_rdy  = 1'b1;
            end
            compared++;
            if ({ds, shcp, stcp, ready, oe} !== {e_ds, e_shcp, e_stcp, e_rdy, 1'b0}) begin
                mismatched++;
                $display("FAIL b2b_T+%0d: got ds/shcp/stcp/ready/oe=%b want %b",
                         k, {ds, shcp, stcp, ready, oe}, {e_ds, e_shcp, e_stcp, e_rdy, 1'b0});
            end
        end
    endtask

    // Reset at T+22 aborts the transfer; a later transfer completes normally.
    task automatic test_mid_reset();
        int stcp_seen;
        stcp_seen = 0;
        data_in = 14'h1555;
        load = 1'b1;
        for (int k = 1; k <= 22; k++) begin
            @(negedge sys_clk);
            load = 1'b0;
            if (stcp) stcp_seen++;
        end
        sys_rst = 1'b1;
        @(negedge sys_clk);
        compared++;
        if ({ds, shcp, stcp, oe, ready} !== 5'b00011 || stcp_seen != 0) begin
            mismatched++;
            $display("FAIL midrst_values: got %b stcp_seen=%0d want 00011 0",
                     {ds, shcp, stcp, oe, ready}, stcp_seen);
        end
        load = 1'b1;
        data_in = 14'h3FFF;
        @(negedge sys_clk);
        sys_rst = 1'b0;
        load = 1'b0;
        compared++;
        if (ready !== 1'b1 || ds !== 1'b0) begin
            mismatched++;
            $display("FAIL midrst_load_ignored: got ready=%b ds=%b want 1 0", ready, ds);
        end
        @(negedge sys_clk);
        data_in = 14'h1234;
        load = 1'b1;
        for (int k = 1; k <= 59; k++) begin
            @(negedge sys_clk);
            load = 1'b0;
            if (k == 1) begin
                compared++;
                if (ready !== 1'b0 || ds !== 1'b0) begin
                    mismatched++;
                    $display("FAIL midrst_start: got ready=%b ds=%b want 0 0", ready, ds);
                end
            end
            if (k == 56 || k == 57 || k == 58 || k == 59) begin
                compared++;
                if ({stcp, ready, oe} !== {(k == 57 || k == 58), (k == 59), (k != 59)}) begin
                    mismatched++;
                    $display("FAIL midrst_end_T+%0d: got stcp/ready/oe=%b", k, {stcp, ready, oe});
                end
            end
        end
    endtask

`ifdef HC595_BLANK_EN
    task automatic test_blank();
        data_in = 14'h2000;
        load = 1'b1;
        blank = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge sys_clk);
            load = 1'b0;
            if (k == 5) blank = 1'b0;
            compared++;
            if (oe !== (k <= 5) || ds !== (k <= 4)) begin
                mismatched++;
                $display("FAIL blank_T+%0d: got oe=%b ds=%b", k, oe, ds);
            end
        end
        repeat (51) @(negedge sys_clk);
        compared++;
        if (ready !== 1'b1 || oe !== 1'b0) begin
            mismatched++;
            $display("FAIL blank_done: got ready=%b oe=%b want 1 0", ready, oe);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_pattern();
        test_ignore();
        test_back_to_back();
        test_mid_reset();
`ifdef HC595_BLANK_EN
        test_blank();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
